neosd_cmd_engine: RTL
=====================

# neosd_cmd_engine

Parametrised SD command-line engine, successor to the fixed 32-bit command FSM: it serialises a command frame with internally generated CRC7, waits for a response with a bounded timeout, and deserialises short or long responses into WORD_W-bit words. Every response is checked for CRC7, index and end-bit errors. It sits between the bus register file and the SD clock generator, on the same strobe/clock-request scheme as the rest of the neosd core.

## Interface
- WORD_W, 32, response word width; legal values are 8, 16 and 32.
- RESP_TIMEOUT, 64, maximum number of bit ticks spent waiting for a response start bit.
- TAIL_BITS, 8, number of idle clock ticks after each transaction; range 1..255.
- clk_i  in  1  system clock.
- rst_i  in  1  reset, asynchronous, active-high.
- clkstrb_i  in  1  SD bit strobe.
- sd_clk_en_i  in  1  SD clock is running and not stalled.
- cmd_idx_i  in  6  command index, latched at start.
- cmd_arg_i  in  32  command argument, latched at start.
- ctrl_rmode_i  in  2  response mode, latched at start: 0 none, 1 short, 2 short without CRC (R3), 3 long (R2).
- ctrl_start_i  in  1  start request.
- busy_o  out  1  a transaction is in progress.
- done_o  out  1  one-cycle pulse when the engine returns to IDLE.
- err_timeout_o, err_crc_o, err_idx_o  out  1 each  sticky error flags, cleared by the next accepted start.
- resp_idx_o  out  6  received response index.
- resp_data_o  out  WORD_W  response word.
- resp_valid_o  out  1  resp_data_o holds a word.
- resp_ready_i  in  1  consumer accepts the word.
- sd_clk_req_o  out  1  SD clock wanted.
- sd_cmd_oe  out  1  CMD pad output enable.
- sd_cmd_o  out  1  CMD pad output.
- sd_cmd_i  in  1  CMD pad input.

## Operation
- Bit tick = clkstrb_i & sd_clk_en_i & sd_clk_req_o. All bit-level progress happens on ticks only.
- IDLE: ctrl_start_i is sampled on any clk_i edge. An accepted start latches the inputs, clears the error flags, sets busy_o, sd_clk_req_o and sd_cmd_oe, and enters WRITE. A start while busy_o=1 is ignored.
- WRITE: sends the 48-bit frame {0,1,idx,arg,crc7,1} MSB first, one bit per tick.
  - CRC7 uses polynomial x^7+x^3+1, initial value 0, and covers the first 40 bits.
  - After bit 47, sd_cmd_oe drops. Mode 0 goes to TAIL; all other modes go to WAIT.
- WAIT: sd_cmd_i is sampled on each tick.
  - A 0 is the response start bit; go to READ.
  - After RESP_TIMEOUT ticks with no start bit, set err_timeout_o and go to TAIL.
- READ: response length is 48 bits in modes 1 and 2, 136 bits in mode 3.
  - Short responses: bits 45..40 go to resp_idx_o, bits 39..8 are the payload, bits 7..1 are the CRC.
  - Long responses: the payload is bits 127..0; the CRC is bits 7..1 and covers bits 127..8.
  - Payload is packed MSB first into WORD_W words: 32/WORD_W words for short, 128/WORD_W words for long.
- HOLD: entered when a word's last bit has been received. resp_valid_o=1 and sd_clk_req_o=0 until resp_ready_i is sampled high. Then resp_valid_o=0, sd_clk_req_o=1, and the engine returns to READ, or to TAIL after the final end bit.
- Checks, evaluated after the end bit:
  - Mode 1 and mode 3: CRC mismatch sets err_crc_o.
  - Mode 1: resp_idx_o != latched idx sets err_idx_o.
  - Any mode: end bit = 0 sets err_crc_o.
  - The transmission bit is not checked.
- TAIL: TAIL_BITS ticks with sd_cmd_oe=0. Then sd_clk_req_o=0, busy_o=0, done_o pulses, and the engine enters IDLE.

## Timing
- Reset values: all outputs 0 except sd_cmd_o=1.
  - Reset asserted mid-transaction forces IDLE, sd_cmd_oe=0 and resp_valid_o=0 immediately; no done_o pulse.
- sd_cmd_o updates on the clk_i edge of each tick. The first bit (0) is driven from the start-accept edge.
- sd_cmd_i is sampled at the tick edge.
- resp_valid_o rises on the tick edge that captures a word's last bit; resp_data_o is stable while it is high.
- resp_ready_i high in the same cycle resp_valid_o rises: the word is consumed on the next edge, so the stall lasts one clk_i cycle.
- If the last payload word and the end bit coincide (WORD_W=32 long response: bit 0 is payload), HOLD is entered first; checks run after the word is accepted.
- done_o is high for exactly 1 cycle. A start in the cycle after done_o is accepted.
- Timeout counter width is clog2(RESP_TIMEOUT+1). The counter resets on entering WAIT.

## Test plan
- CMD0 (idx 0, arg 0, mode 0) -> sd_cmd_o stream 0x400000000095; oe high for exactly 48 ticks; 8 tail ticks; done_o pulse; no errors.
- CMD8 (idx 8, arg 0x1AA, mode 1), response 0x080000 01AA13 driven after 5 idle ticks -> frame 0x48000001AA87; resp_data_o=0x000001AA; resp_idx_o=8; no errors.
- Same CMD8 with response CRC byte 0x15 -> err_crc_o=1. With response index 9 -> err_idx_o=1. Both still complete with done_o.
- Mode 1, CMD line held high -> err_timeout_o after exactly 64 WAIT ticks; no resp_valid_o; done_o after tail.
- Mode 3, WORD_W=32, R2 payload 0x0123..CDEF (128 bits), resp_ready_i held low 10 cycles per word -> 4 words in order; sd_clk_req_o=0 and no ticks consumed during each hold; no errors.
- rst_i pulsed during READ; ctrl_start_i pulsed during WRITE -> reset returns all outputs to reset values with no done_o; the mid-WRITE start is ignored and the frame is unchanged.

Source files
------------

// File: rtl/neosd_cmd_engine.sv
// SD CMD-line engine: sends a CRC7-protected command frame, waits for a
// response and delivers its payload as WORD_W-bit words with backpressure.
module neosd_cmd_engine #(
    parameter int WORD_W       = 32,
    parameter int RESP_TIMEOUT = 64,
    parameter int TAIL_BITS    = 8
) (
    input  logic              clk_i,
    input  logic              rst_i,
    input  logic              clkstrb_i,
    input  logic              sd_clk_en_i,
    input  logic [5:0]        cmd_idx_i,
    input  logic [31:0]       cmd_arg_i,
    input  logic [1:0]        ctrl_rmode_i,
    input  logic              ctrl_start_i,
    output logic              busy_o,
    output logic              done_o,
    output logic              err_timeout_o,
    output logic              err_crc_o,
    output logic              err_idx_o,
    output logic [5:0]        resp_idx_o,
    output logic [WORD_W-1:0] resp_data_o,
    output logic              resp_valid_o,
    input  logic              resp_ready_i,
    output logic              sd_clk_req_o,
    output logic              sd_cmd_oe,
    output logic              sd_cmd_o,
    input  logic              sd_cmd_i
);
    localparam int TW = $clog2(RESP_TIMEOUT + 1);

    localparam logic [2:0] S_IDLE  = 3'd0;
    localparam logic [2:0] S_WRITE = 3'd1;
    localparam logic [2:0] S_WAIT  = 3'd2;
    localparam logic [2:0] S_READ  = 3'd3;
    localparam logic [2:0] S_HOLD  = 3'd4;
    localparam logic [2:0] S_TAIL  = 3'd5;

    logic [2:0]        state_q, state_d;
    logic [7:0]        cnt_q, cnt_d;
    logic [TW-1:0]     tmo_q, tmo_d;
    logic [47:0]       tx_q, tx_d;
    logic [5:0]        idx_q, idx_d;
    logic [1:0]        mode_q, mode_d;
    logic [5:0]        ridx_q, ridx_d;
    logic [WORD_W-1:0] word_q, word_d;
    logic [6:0]        crc_q, crc_d;
    logic [6:0]        rcrc_q, rcrc_d;
    logic              oe_q, oe_d;
    logic              busy_q, busy_d;
    logic              done_q, done_d;
    logic              req_q, req_d;
    logic              valid_q, valid_d;
    logic              et_q, et_d;
    logic              ec_q, ec_d;
    logic              ei_q, ei_d;
    logic              end_q, end_d;
    logic              fin_q, fin_d;

    logic       tick, long_m, pay, wb, crc_in, chk, chk_end;
    logic [7:0] bidx, poff;

    function automatic logic [6:0] crc7_step(input logic [6:0] c, input logic b);
        return {c[5:0], 1'b0} ^ ((c[6] ^ b) ? 7'h09 : 7'h00);
    endfunction

    function automatic logic [47:0] mk_frame(input logic [5:0] idx, input logic [31:0] arg);
        logic [39:0] h;
        logic [6:0]  c;
        h = {2'b01, idx, arg};
        c = '0;
        for (int i = 39; i >= 0; i--) c = crc7_step(c, h[i]);
        return {h, c, 1'b1};
    endfunction

    assign tick   = clkstrb_i & sd_clk_en_i & req_q;
    assign long_m = (mode_q == 2'd3);
    // bidx is the response bit number currently on the line (start bit = len-1)
    assign bidx   = (long_m ? 8'd135 : 8'd47) - cnt_q;
    assign poff   = long_m ? bidx : bidx - 8'd8;
    assign pay    = long_m ? (bidx <= 8'd127) : (bidx <= 8'd39 && bidx >= 8'd8);
    assign wb     = pay && ((poff & 8'(WORD_W - 1)) == 8'd0);
    assign crc_in = long_m ? (bidx <= 8'd127 && bidx >= 8'd8) : (bidx >= 8'd8);

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        tmo_d   = tmo_q;
        tx_d    = tx_q;
        idx_d   = idx_q;
        mode_d  = mode_q;
        ridx_d  = ridx_q;
        word_d  = word_q;
        crc_d   = crc_q;
        rcrc_d  = rcrc_q;
        oe_d    = oe_q;
        busy_d  = busy_q;
        done_d  = 1'b0;
        req_d   = req_q;
        valid_d = valid_q;
        et_d    = et_q;
        ec_d    = ec_q;
        ei_d    = ei_q;
        end_d   = end_q;
        fin_d   = fin_q;
        chk     = 1'b0;
        chk_end = end_q;
        case (state_q)
            S_IDLE: begin
                if (ctrl_start_i) begin
                    state_d = S_WRITE;
                    tx_d    = mk_frame(cmd_idx_i, cmd_arg_i);
                    idx_d   = cmd_idx_i;
                    mode_d  = ctrl_rmode_i;
                    cnt_d   = 8'd0;
                    busy_d  = 1'b1;
                    req_d   = 1'b1;
                    oe_d    = 1'b1;
                    et_d    = 1'b0;
                    ec_d    = 1'b0;
                    ei_d    = 1'b0;
                end
            end
            S_WRITE: begin
                if (tick) begin
                    tx_d  = {tx_q[46:0], 1'b1};
                    cnt_d = cnt_q + 8'd1;
                    if (cnt_q == 8'd47) begin
                        oe_d    = 1'b0;
                        cnt_d   = 8'd0;
                        tmo_d   = '0;
                        state_d = (mode_q == 2'd0) ? S_TAIL : S_WAIT;
                    end
                end
            end
            S_WAIT: begin
                if (tick) begin
                    if (!sd_cmd_i) begin
                        state_d = S_READ;
                        cnt_d   = 8'd1;
                        crc_d   = '0;
                        fin_d   = 1'b0;
                    end else if (tmo_q == TW'(RESP_TIMEOUT - 1)) begin
                        et_d    = 1'b1;
                        cnt_d   = 8'd0;
                        state_d = S_TAIL;
                    end else begin
                        tmo_d = tmo_q + TW'(1);
                    end
                end
            end
            S_READ: begin
                if (tick) begin
                    cnt_d = cnt_q + 8'd1;
                    if (crc_in) crc_d = crc7_step(crc_q, sd_cmd_i);
                    if (!long_m && bidx <= 8'd45 && bidx >= 8'd40)
                        ridx_d = {ridx_q[4:0], sd_cmd_i};
                    if (bidx <= 8'd7 && bidx >= 8'd1)
                        rcrc_d = {rcrc_q[5:0], sd_cmd_i};
                    if (pay) word_d = {word_q[WORD_W-2:0], sd_cmd_i};
                    if (wb) begin
                        valid_d = 1'b1;
                        req_d   = 1'b0;
                        state_d = S_HOLD;
                    end
                    // a word ending on the end bit defers the checks past HOLD
                    if (bidx == 8'd0) begin
                        end_d = sd_cmd_i;
                        fin_d = 1'b1;
                        if (!wb) begin
                            chk     = 1'b1;
                            chk_end = sd_cmd_i;
                            cnt_d   = 8'd0;
                            state_d = S_TAIL;
                        end
                    end
                end
            end
            S_HOLD: begin
                if (resp_ready_i) begin
                    valid_d = 1'b0;
                    req_d   = 1'b1;
                    if (fin_q) begin
                        chk     = 1'b1;
                        cnt_d   = 8'd0;
                        state_d = S_TAIL;
                    end else begin
                        state_d = S_READ;
                    end
                end
            end
            S_TAIL: begin
                if (tick) begin
                    if (cnt_q == 8'(TAIL_BITS - 1)) begin
                        state_d = S_IDLE;
                        cnt_d   = 8'd0;
                        req_d   = 1'b0;
                        busy_d  = 1'b0;
                        done_d  = 1'b1;
                    end else begin
                        cnt_d = cnt_q + 8'd1;
                    end
                end
            end
            default: state_d = S_IDLE;
        endcase
        if (chk) begin
            if (mode_q != 2'd2 && crc_q != rcrc_q) ec_d = 1'b1;
            if (!chk_end) ec_d = 1'b1;
            if (mode_q == 2'd1 && ridx_q != idx_q) ei_d = 1'b1;
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q <= S_IDLE;
            cnt_q   <= '0;
            tmo_q   <= '0;
            tx_q    <= '1;
            idx_q   <= '0;
            mode_q  <= '0;
            ridx_q  <= '0;
            word_q  <= '0;
            crc_q   <= '0;
            rcrc_q  <= '0;
            oe_q    <= 1'b0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            req_q   <= 1'b0;
            valid_q <= 1'b0;
            et_q    <= 1'b0;
            ec_q    <= 1'b0;
            ei_q    <= 1'b0;
            end_q   <= 1'b0;
            fin_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            tmo_q   <= tmo_d;
            tx_q    <= tx_d;
            idx_q   <= idx_d;
            mode_q  <= mode_d;
            ridx_q  <= ridx_d;
            word_q  <= word_d;
            crc_q   <= crc_d;
            rcrc_q  <= rcrc_d;
            oe_q    <= oe_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
            req_q   <= req_d;
            valid_q <= valid_d;
            et_q    <= et_d;
            ec_q    <= ec_d;
            ei_q    <= ei_d;
            end_q   <= end_d;
            fin_q   <= fin_d;
        end
    end

    assign busy_o        = busy_q;
    assign done_o        = done_q;
    assign err_timeout_o = et_q;
    assign err_crc_o     = ec_q;
    assign err_idx_o     = ei_q;
    assign resp_idx_o    = ridx_q;
    assign resp_data_o   = word_q;
    assign resp_valid_o  = valid_q;
    assign sd_clk_req_o  = req_q;
    assign sd_cmd_oe     = oe_q;
    assign sd_cmd_o      = tx_q[47];
endmodule
